// File: rtl/uart_rx_fifo.sv
// UART receiver (N data bits, optional parity, 1-2 stops) feeding a first-word-fall-through FIFO.
// Entry is pushed the cycle after the final stop sample; a push into a full FIFO with no pop is dropped (overrun).
module uart_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          rx_done,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP, WAIT_IDLE} state_t;

  state_t            state, state_d;
  logic              rx_meta, rx_s, rx_prev;
  logic [CW-1:0]     cnt, cnt_d;
  logic [3:0]        bit_idx, bit_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              perr, perr_d, ferr, ferr_d, stop_err;
  logic              push_vld, push_d;
  logic [EW-1:0]     push_dat, push_dat_d;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, full, do_rd, do_wr;
  logic [EW-1:0]     head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      sh       <= sh_d;
      perr     <= perr_d;
      ferr     <= ferr_d;
      push_vld <= push_d;
      push_dat <= push_dat_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 1'b1;
    bit_d      = bit_idx;
    sh_d       = sh;
    perr_d     = perr;
    ferr_d     = ferr;
    push_d     = 1'b0;
    push_dat_d = push_dat;
    stop_err   = ferr | ~rx_s;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) begin
          state_d = START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh[DATA_W-1:1]};
          if (bit_idx == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PARITY_BIT : STOP;
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? (^sh ^ rx_s) : !(^sh ^ rx_s);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d  = '0;
          ferr_d = stop_err;
          if (bit_idx == STOP_LAST) begin
            bit_d      = '0;
            push_d     = 1'b1;
            push_dat_d = {sh, perr, stop_err};
            // A low final stop bit may be a break; wait for the line to recover.
            state_d    = rx_s ? IDLE : WAIT_IDLE;
          end else begin
            bit_d = bit_idx + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en && !empty;
  assign do_wr = push_vld && (!full || do_rd);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  assign valid      = !empty;
  assign data_out   = empty ? '0 : head[EW-1:2];
  assign parity_err = !empty && head[1];
  assign frame_err  = !empty && head[0];
  assign rx_done    = push_vld;
  assign overrun    = push_vld && full && !do_rd;
  assign fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench: instance a is 8N1, instance b is 8E2; both at 16 clocks per bit, depth 4.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_a, rx_b, rd_a, rd_b;
  logic [7:0] dout_a, dout_b;
  logic       val_a, val_b, pe_a, pe_b, fe_a, fe_b, done_a, done_b, ovr_a, ovr_b;
  logic [2:0] cnt_a, cnt_b;

  int checks = 0, failures = 0;
  int ndone_a = 0, ndone_b = 0, novr_a = 0, novr_b = 0;
  int exp_done_a = 0, exp_done_b = 0;
  logic [9:0] q_a[$], q_b[$];
  bit seen;

  uart_rx_fifo u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rd_en(rd_a), .data_out(dout_a), .valid(val_a),
    .parity_err(pe_a), .frame_err(fe_a), .rx_done(done_a), .overrun(ovr_a), .fifo_count(cnt_a)
  );

  uart_rx_fifo #(.PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rd_en(rd_b), .data_out(dout_b), .valid(val_b),
    .parity_err(pe_b), .frame_err(fe_b), .rx_done(done_b), .overrun(ovr_b), .fifo_count(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done_a) ndone_a++;
    if (!rst && ovr_a)  novr_a++;
    if (!rst && done_b) ndone_b++;
    if (!rst && ovr_b)  novr_b++;
    if (!rst && rd_a && val_a) begin
      if (q_a.size() == 0) chk("pop_a_unexpected", {dout_a, pe_a, fe_a}, 32'hFFFF_FFFF);
      else chk("pop_a_entry", {dout_a, pe_a, fe_a}, q_a.pop_front());
    end
    if (!rst && rd_b && val_b) begin
      if (q_b.size() == 0) chk("pop_b_unexpected", {dout_b, pe_b, fe_b}, 32'hFFFF_FFFF);
      else chk("pop_b_entry", {dout_b, pe_b, fe_b}, q_b.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit inst_b, input logic [7:0] d, input bit has_par,
                      input logic p, input int nstop, input logic last_stop);
    logic [15:0] bits;
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (has_par) begin bits[n] = p; n++; end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = (i == nstop - 1) ? last_stop : 1'b1;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      if (inst_b) rx_b = bits[i]; else rx_a = bits[i];
      idle(16);
    end
    if (inst_b) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic pop(input bit inst_b);
    if (inst_b) rd_b = 1'b1; else rd_a = 1'b1;
    idle(1);
    if (inst_b) rd_b = 1'b0; else rd_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rd_a = 1'b0; rd_b = 1'b0;
    idle(3);
    rst = 1'b0;
    chk("rst_valid_a", val_a, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_flags_a", {pe_a, fe_a, done_a, ovr_a}, 0);
    chk("rst_valid_b", val_b, 0);
    chk("rst_count_b", cnt_b, 0);
    idle(20);

    // even parity: 0x03 has even ones, so p=1 is a parity error
    q_b.push_back({8'h03, 1'b1, 1'b0});
    send(1, 8'h03, 1, 1'b1, 2, 1'b1); exp_done_b++;
    idle(10);
    chk("par_err_set", pe_b, 1);
    chk("par_dout", dout_b, 8'h03);
    chk("par_count", cnt_b, 1);
    pop(1);
    q_b.push_back({8'h03, 1'b0, 1'b0});
    send(1, 8'h03, 1, 1'b0, 2, 1'b1); exp_done_b++;
    idle(10);
    chk("par_err_clr", pe_b, 0);
    chk("par_valid", val_b, 1);
    pop(1);

    // second stop low, then a three-frame break
    q_b.push_back({8'h5A, 1'b0, 1'b1});
    send(1, 8'h5A, 1, 1'b0, 2, 1'b0); exp_done_b++;
    idle(16);
    chk("stop2_frame_err", fe_b, 1);
    q_b.push_back({8'h00, 1'b0, 1'b1});
    rx_b = 1'b0; exp_done_b++;
    idle(576);
    chk("break_done_cnt", ndone_b, exp_done_b);
    chk("break_count", cnt_b, 2);
    rx_b = 1'b1;
    idle(40);
    chk("break_no_more", ndone_b, exp_done_b);
    chk("break_count_hi", cnt_b, 2);
    pop(1); pop(1);
    chk("b_drained_valid", val_b, 0);
    chk("b_drained_dout", dout_b, 0);
    chk("b_no_overrun", novr_b, 0);

    // 8N1 basic frame
    q_a.push_back({8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 0, 1'b0, 1, 1'b1); exp_done_a++;
    idle(10);
    chk("a5_done", ndone_a, exp_done_a);
    chk("a5_valid", val_a, 1);
    chk("a5_dout", dout_a, 8'hA5);
    chk("a5_flags", {pe_a, fe_a}, 0);
    pop(0);
    chk("a5_pop_valid", val_a, 0);
    chk("a5_pop_dout", dout_a, 0);

    // overrun on the fifth frame
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q_a.push_back({8'(i), 1'b0, 1'b0});
      send(0, 8'(i), 0, 1'b0, 1, 1'b1); exp_done_a++;
      idle(4);
      if (i == 4) chk("ovr_before", novr_a, 0);
    end
    idle(10);
    chk("ovr_done", ndone_a, exp_done_a);
    chk("ovr_pulse", novr_a, 1);
    chk("ovr_count", cnt_a, 4);
    for (int i = 0; i < 4; i++) pop(0);
    chk("ovr_drained", val_a, 0);

    // pop in the push cycle while full
    for (int i = 1; i <= 4; i++) begin
      q_a.push_back({8'h10 + 8'(i), 1'b0, 1'b0});
      send(0, 8'h10 + 8'(i), 0, 1'b0, 1, 1'b1); exp_done_a++;
      idle(4);
    end
    q_a.push_back({8'h15, 1'b0, 1'b0}); exp_done_a++;
    seen = 1'b0;
    fork
      send(0, 8'h15, 0, 1'b0, 1, 1'b1);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          idle(1);
          if (done_a) begin seen = 1'b1; pop(0); end
        end
        chk("pp_rx_done_seen", seen, 1);
      end
    join
    idle(10);
    chk("pp_count", cnt_a, 4);
    chk("pp_no_overrun", novr_a, 1);
    for (int i = 0; i < 4; i++) pop(0);
    chk("pp_drained", val_a, 0);

    // 6-cycle glitch
    rx_a = 1'b0; idle(6); rx_a = 1'b1;
    idle(60);
    chk("glitch_no_done", ndone_a, exp_done_a);
    chk("glitch_empty", val_a, 0);

    // reset mid data bit 4 with one entry held
    q_a.push_back({8'h99, 1'b0, 1'b0});
    send(0, 8'h99, 0, 1'b0, 1, 1'b1); exp_done_a++;
    idle(10);
    chk("pre_rst_count", cnt_a, 1);
    fork
      send(0, 8'hF0, 0, 1'b0, 1, 1'b1);
      begin
        idle(88);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", val_a, 0);
        chk("mid_rst_dout", dout_a, 0);
        chk("mid_rst_count", cnt_a, 0);
        chk("mid_rst_flags", {pe_a, fe_a, done_a, ovr_a}, 0);
        q_a.delete();
      end
    join
    idle(40);
    chk("post_rst_no_done", ndone_a, exp_done_a);
    chk("post_rst_empty", val_a, 0);
    q_a.push_back({8'h3C, 1'b0, 1'b0});
    send(0, 8'h3C, 0, 1'b0, 1, 1'b1); exp_done_a++;
    idle(10);
    chk("3c_done", ndone_a, exp_done_a);
    chk("3c_dout", dout_a, 8'h3C);
    pop(0);
    idle(4);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the next generation of our single-format receiver. It adds configurable data width, oversampling ratio, parity, stop-bit count, per-frame error flags and a small first-word-fall-through output FIFO. It sits between the serial `rx` pin and the consuming logic, and keeps the existing `rx` / `rx_done` / `data_out` port semantics so current agents and monitors extend to it directly.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, 16: clk cycles per bit; even, ≥ 4.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of 2, ≥ 2.
---
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pops the FIFO head when `valid`=1.
- `data_out`  out  DATA_W  FIFO head data; 0 when empty.
- `valid`  out  1  FIFO non-empty.
- `parity_err`  out  1  parity error flag of the head entry; 0 when `PARITY`=0 or FIFO empty.
- `frame_err`  out  1  framing error flag of the head entry.
- `rx_done`  out  1  one-cycle pulse per completed frame, including frames dropped by overrun.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on `rx_s` 1→0, clear the bit counter and go to START.
  - START: at count CLKS_PER_BIT/2−1, sample `rx_s`. If 1, it is a glitch: return to IDLE with no push. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, DATA_W samples. Go to PARITY if PARITY≠0, else STOP.
  - PARITY: one sample. Even mode: error if XOR(data, p) = 1. Odd mode: error if XOR(data, p) = 0.
  - STOP: STOP_BITS samples. `frame_err` = any stop sample equals 0.
  - On the final stop sample: push {data, parity_err, frame_err} and pulse `rx_done`. If the final stop sample is 0, go to WAIT_IDLE; otherwise go to IDLE.
  - WAIT_IDLE: remain until `rx_s` = 1, then go to IDLE. This handles a break, which yields data 0 with `frame_err`=1 and produces exactly one entry.
- Frames with parity or framing errors are still pushed, with their flags.
- FIFO behaviour:
  - First-word-fall-through: outputs reflect the head entry.
  - `rd_en` with `valid`=0 is ignored.
  - Push while full and no pop: the frame is dropped, `overrun` pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop while empty: only the push occurs.
- Pointers wrap modulo FIFO_DEPTH. Count saturates logically at FIFO_DEPTH, never beyond.

## Timing
- Reset, or `rst` asserted mid-frame, takes effect at the next edge:
  - FSM to IDLE, counters 0, FIFO empty, synchroniser = 1.
  - `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `rx_done`=0, `overrun`=0, `fifo_count`=0.
  - A partial frame is discarded.
- Synchroniser latency: 2 cycles from an `rx` edge to `rx_s`.
- Start sample occurs CLKS_PER_BIT/2 cycles after the falling edge of `rx_s`. Each later sample follows the previous one by exactly CLKS_PER_BIT cycles.
- `rx_done` and the push happen in the cycle after the final stop sample. `valid`, `data_out`, `fifo_count` and the flags update in the following cycle.
- A pop on edge N makes the next entry visible after edge N.
- Back-to-back frames: after the last stop sample the FSM is already in IDLE, so a start edge immediately after the stop bit is accepted.

## Test plan
- 8N1, CLKS_PER_BIT=16: send 0xA5 → one `rx_done` pulse; `valid`=1, `data_out`=0xA5, both flags 0; `rd_en` → `valid`=0, `data_out`=0.
- PARITY=1 (even): send 0x03 with p=1 → `parity_err`=1, `data_out`=0x03. Send 0x03 with p=0 → `parity_err`=0.
- STOP_BITS=2: send 0x5A with the second stop bit 0 → `frame_err`=1. Then hold `rx` low for 3 frame times → exactly one extra entry, 0x00 with `frame_err`=1, and no further entries until `rx` returns high.
- FIFO_DEPTH=4, no reads: send 5 frames 0x01..0x05 → 5 `rx_done` pulses, 1 `overrun` on the 5th, `fifo_count`=4. Four pops return 0x01..0x04.
- Fill the FIFO, then assert `rd_en` in the push cycle of a 5th frame → no overrun, count stays 4, and the 5th frame is read last. A 6-cycle low pulse on `rx` → no push, no `rx_done`.
- Assert `rst` for 1 cycle in the middle of DATA bit 4 → all outputs at reset values. The next clean frame 0x3C is received correctly.
